// File: rtl/tutorial_ctrl_pkg.sv
// Shared encodings, field offsets and FSM state type for the tutorial control sequencer.
package tutorial_ctrl_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LDI  = 2'b01;
  localparam logic [1:0] OP_ADDI = 2'b10;
  localparam logic [1:0] OP_MV   = 2'b11;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_Z = 2'b10;

  // Field offsets measured from the bottom of the op/rd/rs block, which sits just above imm.
  localparam int OP_OFS = 4;
  localparam int RD_OFS = 2;
  localparam int RS_OFS = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_EXEC1 = 2'b01,
    ST_EXEC2 = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  typedef struct packed {
    logic ra_out;
    logic rb_out;
    logic rz_out;
    logic ra_in;
    logic rb_in;
    logic rz_in;
  } strobe_t;

  // One-hot {A, B, Z} for a register select; reserved code maps to nothing.
  function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
    logic [2:0] oh;
    case (sel)
      SEL_A:   oh = 3'b100;
      SEL_B:   oh = 3'b010;
      SEL_Z:   oh = 3'b001;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/tutorial_ctrl_decode.sv
// Combinational decode of one micro-instruction into per-step strobes and an illegal flag.
module tutorial_ctrl_decode
  import tutorial_ctrl_pkg::*;
#(
  parameter int IMM_W = 8
) (
  input  logic [IMM_W+5:0] instr,
  output logic             two_step,
  output logic             illegal,
  output logic             use_add_imm,
  output logic             use_ra_imm,
  output strobe_t          step1,
  output strobe_t          step2
);

  logic [1:0] op_s;
  logic [1:0] rd_s;
  logic [1:0] rs_s;
  logic [2:0] rd_oh_s;
  logic [2:0] rs_oh_s;

  assign op_s    = instr[IMM_W+OP_OFS +: 2];
  assign rd_s    = instr[IMM_W+RD_OFS +: 2];
  assign rs_s    = instr[IMM_W+RS_OFS +: 2];
  assign rd_oh_s = sel_onehot(rd_s);
  assign rs_oh_s = sel_onehot(rs_s);

  // Illegal detection followed by per-opcode strobe generation; illegal ops behave as NOP.
  always_comb begin
    illegal     = (rd_s[1] == 1'b1)
                | (((op_s == OP_ADDI) || (op_s == OP_MV)) && (rs_s == 2'b11))
                | ((op_s == OP_LDI) && (rd_s != SEL_A))
                | ((op_s == OP_ADDI) && (rs_s == SEL_Z))
                | ((op_s == OP_MV) && (rs_s == rd_s));
    two_step    = 1'b0;
    use_add_imm = 1'b0;
    use_ra_imm  = 1'b0;
    step1       = 6'b000000;
    step2       = 6'b000000;
    if (illegal) begin
      two_step = 1'b0;
    end else begin
      case (op_s)
        OP_LDI: begin
          use_ra_imm  = 1'b1;
          step1.ra_in = 1'b1;
        end
        OP_ADDI: begin
          two_step    = 1'b1;
          use_add_imm = 1'b1;
          {step1.ra_out, step1.rb_out, step1.rz_out} = rs_oh_s;
          step1.rz_in  = 1'b1;
          step2.rz_out = 1'b1;
          {step2.ra_in, step2.rb_in, step2.rz_in} = rd_oh_s;
        end
        OP_MV: begin
          {step1.ra_out, step1.rb_out, step1.rz_out} = rs_oh_s;
          {step1.ra_in, step1.rb_in, step1.rz_in}    = rd_oh_s;
        end
        default: begin
          two_step = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/tutorial_ctrl_seq.sv
// Hardwired control sequencer driving the A/B/Z DataPath strobes from one handshaked instruction.
// Optional retire counter output enabled by `define TUTORIAL_CTRL_RETIRE_CNT_EN.
module tutorial_ctrl_seq
  import tutorial_ctrl_pkg::*;
#(
  parameter int IMM_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             instr_valid,
  input  logic [IMM_W+5:0] instr,
  output logic             instr_ready,
  output logic             busy,
  output logic             done,
  output logic             illegal,
`ifdef TUTORIAL_CTRL_RETIRE_CNT_EN
  output logic [CNT_W-1:0] retired_cnt,
`endif
  output logic             RAout,
  output logic             RBout,
  output logic             RZout,
  output logic             RAin,
  output logic             RBin,
  output logic             RZin,
  output logic [IMM_W-1:0] AddImmediate,
  output logic [IMM_W-1:0] RegisterAImmediate
);

  state_e           state_q, state_d;
  logic [IMM_W+5:0] instr_q, instr_d;
  strobe_t          stb_q, stb_d;
  logic [IMM_W-1:0] add_imm_q, add_imm_d;
  logic [IMM_W-1:0] ra_imm_q, ra_imm_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  logic             accept_s;
  logic             dec_two_step_s;
  logic             dec_illegal_s;
  logic             dec_use_add_s;
  logic             dec_use_ra_s;
  strobe_t          dec_step1_s;
  strobe_t          dec_step2_s;

  assign accept_s = instr_valid & ready_q;

  // Decoding instr_d lets the EXEC1 strobes be registered on the accept edge itself.
  tutorial_ctrl_decode #(.IMM_W(IMM_W)) u_decode (
    .instr       (instr_d),
    .two_step    (dec_two_step_s),
    .illegal     (dec_illegal_s),
    .use_add_imm (dec_use_add_s),
    .use_ra_imm  (dec_use_ra_s),
    .step1       (dec_step1_s),
    .step2       (dec_step2_s)
  );

  // Next state and the output values that belong to that next state.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    stb_d     = 6'b000000;
    add_imm_d = {IMM_W{1'b0}};
    ra_imm_d  = {IMM_W{1'b0}};
    done_d    = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d   = ST_EXEC1;
          instr_d   = instr;
          stb_d     = dec_step1_s;
          add_imm_d = dec_use_add_s ? instr[IMM_W-1:0] : {IMM_W{1'b0}};
          ra_imm_d  = dec_use_ra_s ? instr[IMM_W-1:0] : {IMM_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC1: begin
        if (dec_two_step_s) begin
          state_d = ST_EXEC2;
          stb_d   = dec_step2_s;
        end else begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          illegal_d = dec_illegal_s;
        end
      end
      ST_EXEC2: begin
        state_d   = ST_DONE;
        done_d    = 1'b1;
        illegal_d = dec_illegal_s;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low clear.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q   <= ST_IDLE;
      instr_q   <= {(IMM_W+6){1'b0}};
      stb_q     <= 6'b000000;
      add_imm_q <= {IMM_W{1'b0}};
      ra_imm_q  <= {IMM_W{1'b0}};
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      stb_q     <= stb_d;
      add_imm_q <= add_imm_d;
      ra_imm_q  <= ra_imm_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

`ifdef TUTORIAL_CTRL_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Legal retirements (including NOP) counted as DONE is left; wraps naturally.
  always_comb begin
    if ((state_q == ST_DONE) && !illegal_q) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Retire counter register.
  always_ff @(posedge clock) begin
    if (!clear) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign retired_cnt = cnt_q;
`endif

  assign instr_ready        = ready_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign illegal            = illegal_q;
  assign RAout              = stb_q.ra_out;
  assign RBout              = stb_q.rb_out;
  assign RZout              = stb_q.rz_out;
  assign RAin               = stb_q.ra_in;
  assign RBin               = stb_q.rb_in;
  assign RZin               = stb_q.rz_in;
  assign AddImmediate       = add_imm_q;
  assign RegisterAImmediate = ra_imm_q;

endmodule

// File: tb/tb_tutorial_ctrl_seq.sv
// Scoreboard bench for tutorial_ctrl_seq: expected per-cycle outputs queued at accept, popped each cycle.
module tb_tutorial_ctrl_seq;

  logic        clock;
  logic        clear;
  logic        instr_valid;
  logic [13:0] instr;
  logic        instr_ready, busy, done, illegal;
  logic        RAout, RBout, RZout, RAin, RBin, RZin;
  logic [7:0]  AddImmediate, RegisterAImmediate;
`ifdef TUTORIAL_CTRL_RETIRE_CNT_EN
  logic [15:0] retired_cnt;
  logic [15:0] cnt_before;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] dp_a = 8'h00;
  logic [7:0] dp_b = 8'h00;
  logic [7:0] dp_z = 8'h00;

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       done;
    logic       illegal;
    logic [5:0] stb;
    logic [7:0] add_imm;
    logic [7:0] ra_imm;
  } rec_t;

  rec_t exp_q[$];

  tutorial_ctrl_seq #(.IMM_W(8), .CNT_W(16)) dut (
    .clock              (clock),
    .clear              (clear),
    .instr_valid        (instr_valid),
    .instr              (instr),
    .instr_ready        (instr_ready),
    .busy               (busy),
    .done               (done),
    .illegal            (illegal),
`ifdef TUTORIAL_CTRL_RETIRE_CNT_EN
    .retired_cnt        (retired_cnt),
`endif
    .RAout              (RAout),
    .RBout              (RBout),
    .RZout              (RZout),
    .RAin               (RAin),
    .RBin               (RBin),
    .RZin               (RZin),
    .AddImmediate       (AddImmediate),
    .RegisterAImmediate (RegisterAImmediate)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [13:0] enc(input logic [1:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic rec_t mk(input logic r, input logic b, input logic d, input logic il,
                              input logic [5:0] s, input logic [7:0] ai, input logic [7:0] ri);
    rec_t x;
    x.ready = r; x.busy = b; x.done = d; x.illegal = il;
    x.stb = s; x.add_imm = ai; x.ra_imm = ri;
    return x;
  endfunction

  function automatic rec_t observed();
    return mk(instr_ready, busy, done, illegal,
              {RAout, RBout, RZout, RAin, RBin, RZin}, AddImmediate, RegisterAImmediate);
  endfunction

  function automatic logic [5:0] out_vec(input logic [1:0] s);
    case (s)
      2'b00:   return 6'b100000;
      2'b01:   return 6'b010000;
      2'b10:   return 6'b001000;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic logic [5:0] in_vec(input logic [1:0] s);
    case (s)
      2'b00:   return 6'b000100;
      2'b01:   return 6'b000010;
      2'b10:   return 6'b000001;
      default: return 6'b000000;
    endcase
  endfunction

  // Reference expectation: cycles EXEC1 [EXEC2] DONE IDLE after the accept edge.
  task automatic push_expect(input logic [13:0] ins);
    logic [1:0] op, rd, rs;
    logic [7:0] imm;
    logic       bad;
    op = ins[13:12]; rd = ins[11:10]; rs = ins[9:8]; imm = ins[7:0];
    bad = (rd == 2'b10) || (rd == 2'b11)
       || (((op == 2'b10) || (op == 2'b11)) && (rs == 2'b11))
       || ((op == 2'b01) && (rd != 2'b00))
       || ((op == 2'b10) && (rs == 2'b10))
       || ((op == 2'b11) && (rs == rd));
    if (bad || (op == 2'b00)) begin
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 6'b000000, 8'h00, 8'h00));
    end else if (op == 2'b01) begin
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 6'b000100, 8'h00, imm));
    end else if (op == 2'b10) begin
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, out_vec(rs) | 6'b000001, imm, 8'h00));
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 6'b001000 | in_vec(rd), 8'h00, 8'h00));
    end else begin
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, out_vec(rs) | in_vec(rd), 8'h00, 8'h00));
    end
    exp_q.push_back(mk(1'b0, 1'b1, 1'b1, bad, 6'b000000, 8'h00, 8'h00));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 8'h00, 8'h00));
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Pop one expected cycle, compare, check strobe invariants and advance the DataPath model.
  task automatic check_rec(input string tag);
    rec_t e, o;
    logic [7:0] bus, na, nb, nz;
    e = exp_q.pop_front();
    o = observed();
    chk(tag, 32'(o), 32'(e));
    chk({tag, "_one_out"}, 32'(($countones({RAout, RBout, RZout}) <= 1) ? 1 : 0), 32'd1);
    chk({tag, "_in_out"}, 32'({RAin & RAout, RBin & RBout, RZin & RZout}), 32'd0);
    bus = RAout ? dp_a : (RBout ? dp_b : (RZout ? dp_z : 8'h00));
    na = dp_a; nb = dp_b; nz = dp_z;
    if (RAin) na = (RAout | RBout | RZout) ? bus : RegisterAImmediate;
    if (RBin) nb = bus;
    if (RZin) nz = bus + AddImmediate;
    dp_a = na; dp_b = nb; dp_z = nz;
  endtask

  task automatic issue(input string tag, input logic [13:0] ins, input logic hold,
                       input logic [13:0] next_ins);
    int n;
    instr = ins;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    chk({tag, "_ready_wait"}, 32'(instr_ready), 32'd1);
    @(posedge clock); #1;
    if (hold) instr = next_ins;
    else instr_valid = 1'b0;
    push_expect(ins);
    while (exp_q.size() > 0) begin
      check_rec(tag);
      if (exp_q.size() > 0) begin
        @(posedge clock); #1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b0;
    instr_valid = 1'b1;
    instr = enc(2'b01, 2'b00, 2'b00, 8'h05);

    // Reset with a pending instruction: nothing may be accepted.
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      chk("reset_outputs", 32'(observed()), 32'd0);
    end
    clear = 1'b1;
    @(posedge clock); #1;
    chk("reset_release", 32'(observed()), 32'(mk(1'b1, 1'b0, 1'b0, 1'b0, 6'b0, 8'h00, 8'h00)));
`ifdef TUTORIAL_CTRL_RETIRE_CNT_EN
    chk("cnt_reset", 32'(retired_cnt), 32'd0);
`endif
    instr_valid = 1'b0;
    @(posedge clock); #1;

    issue("ldi_a5", enc(2'b01, 2'b00, 2'b00, 8'h05), 1'b0, 14'd0);
    issue("addi_b_a_5", enc(2'b10, 2'b01, 2'b00, 8'h05), 1'b0, 14'd0);
    chk("dp_b_after_addi", 32'(dp_b), 32'h0A);

    issue("b2b_ldi", enc(2'b01, 2'b00, 2'b00, 8'h09), 1'b1, enc(2'b11, 2'b01, 2'b00, 8'h00));
    issue("b2b_mv", enc(2'b11, 2'b01, 2'b00, 8'h00), 1'b0, 14'd0);
    chk("dp_b_after_mv", 32'(dp_b), 32'h09);

    issue("addi_a_b_ff", enc(2'b10, 2'b00, 2'b01, 8'hFF), 1'b0, 14'd0);
    chk("dp_a_after_addi_wrap", 32'(dp_a), 32'h08);

`ifdef TUTORIAL_CTRL_RETIRE_CNT_EN
    cnt_before = retired_cnt;
`endif
    issue("ill_mv_aa", enc(2'b11, 2'b00, 2'b00, 8'h00), 1'b0, 14'd0);
    issue("ill_ldi_b", enc(2'b01, 2'b01, 2'b00, 8'h03), 1'b0, 14'd0);
    issue("ill_addi_bz", enc(2'b10, 2'b01, 2'b10, 8'h01), 1'b0, 14'd0);
`ifdef TUTORIAL_CTRL_RETIRE_CNT_EN
    chk("cnt_illegal_hold", 32'(retired_cnt), 32'(cnt_before));
`endif
    issue("nop", enc(2'b00, 2'b00, 2'b11, 8'h7E), 1'b0, 14'd0);
`ifdef TUTORIAL_CTRL_RETIRE_CNT_EN
    chk("cnt_nop_inc", 32'(retired_cnt), 32'(cnt_before + 16'd1));
`endif

    // Reset while ADDI sits in EXEC1.
    instr = enc(2'b10, 2'b01, 2'b00, 8'h05);
    instr_valid = 1'b1;
    chk("abort_ready", 32'(instr_ready), 32'd1);
    @(posedge clock); #1;
    instr_valid = 1'b0;
    chk("abort_exec1", 32'(observed()),
        32'(mk(1'b0, 1'b1, 1'b0, 1'b0, 6'b100001, 8'h05, 8'h00)));
    clear = 1'b0;
    @(posedge clock); #1;
    chk("abort_cleared", 32'(observed()), 32'd0);
    clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("abort_no_done", 32'(observed()), 32'(mk(1'b1, 1'b0, 1'b0, 1'b0, 6'b0, 8'h00, 8'h00)));
    end

    issue("ldi_a7", enc(2'b01, 2'b00, 2'b00, 8'h07), 1'b0, 14'd0);
    chk("dp_a_after_ldi7", 32'(dp_a), 32'h07);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
